// File: rtl/dmem_store_buffer.sv
// Data-memory responder with a FIFO store buffer in front of a word RAM.
// Stores drain one per cycle when the RAM port is free; loads forward from the newest buffered store.
module dmem_store_buffer #(
  parameter int MEM_WORDS = 64,
  parameter int SB_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        memwrite,
  input  logic [31:0]                 dataadr,
  input  logic [31:0]                 writedata,
  input  logic                        mem_busy,
  output logic [31:0]                 readdata,
  output logic                        stall,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        commit_valid,
  output logic [31:0]                 commit_addr,
  output logic [31:0]                 commit_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [MEM_WORDS];
  logic [AW-1:0] r_sbIdx [SB_DEPTH];
  logic [31:0]   r_sbData [SB_DEPTH];
  logic [PW-1:0] r_headPtr;
  logic [PW-1:0] r_tailPtr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_index;
  logic          w_push;
  logic          w_drain;
  logic          w_full;
  logic          w_fwdHit;
  logic [31:0]   w_fwdData;
  logic [PW-1:0] w_slot;
  logic          w_unusedAdrBits;

  assign w_index         = dataadr[AW+1:2];
  assign w_unusedAdrBits = ^{dataadr[31:AW+2], dataadr[1:0]};

  // A full buffer stalls even when a drain frees a slot this same cycle.
  assign w_full  = (r_count == CW'(SB_DEPTH));
  assign stall   = memwrite & w_full;
  assign w_push  = memwrite & ~w_full;
  assign w_drain = (r_count != '0) & ~mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else begin
      if (w_push)  r_tailPtr <= r_tailPtr + PW'(1);
      if (w_drain) r_headPtr <= r_headPtr + PW'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer slots and RAM hold no reset; validity is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sbIdx[r_tailPtr]  <= w_index;
      r_sbData[r_tailPtr] <= writedata;
    end
    if (w_drain) r_mem[r_sbIdx[r_headPtr]] <= r_sbData[r_headPtr];
  end

  // Walk from oldest to newest so the youngest matching entry wins.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_slot    = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_slot = r_headPtr + PW'(k);
      if ((CW'(k) < r_count) && (r_sbIdx[w_slot] == w_index)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_sbData[w_slot];
      end
    end
  end

  assign readdata     = w_fwdHit ? w_fwdData : r_mem[w_index];
  assign sb_count     = r_count;
  assign commit_valid = w_drain;
  assign commit_addr  = w_drain ? {{(30-AW){1'b0}}, r_sbIdx[r_headPtr], 2'b00} : 32'd0;
  assign commit_data  = w_drain ? r_sbData[r_headPtr] : 32'd0;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer: checks commits at the RAM end,
// forwarding, stall on full, pointer wrap, address wrap and async reset.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        memBusy;
  logic [31:0] readdata;
  logic        stall;
  logic [2:0]  sbCount;
  logic        commitValid;
  logic [31:0] commitAddr;
  logic [31:0] commitData;

  int checks = 0;
  int errors = 0;

  dmem_store_buffer #(.MEM_WORDS(64), .SB_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .mem_busy     (memBusy),
    .readdata     (readdata),
    .stall        (stall),
    .sb_count     (sbCount),
    .commit_valid (commitValid),
    .commit_addr  (commitAddr),
    .commit_data  (commitData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] data, input logic busy);
    memwrite  = mw;
    dataadr   = adr;
    writedata = data;
    memBusy   = busy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCommit(input string tag, input logic [31:0] adr, input logic [31:0] data);
    checkOutput({tag, "_valid"}, 32'(commitValid), 32'd1);
    checkOutput({tag, "_addr"}, commitAddr, adr);
    checkOutput({tag, "_data"}, commitData, data);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    #3;
    checkOutput("rst_count", 32'(sbCount), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_cvalid", 32'(commitValid), 32'd0);
    checkOutput("rst_caddr", commitAddr, 32'd0);
    checkOutput("rst_cdata", commitData, 32'd0);
    nextCycle();
    rst = 1'b1;

    // Single store then commit one cycle later.
    applyStimulus(1'b1, 32'd84, 32'd7, 1'b0);
    @(negedge clk);
    checkOutput("t1_stall", 32'(stall), 32'd0);
    checkOutput("t1_cnt0", 32'(sbCount), 32'd0);
    checkOutput("t1_noc", 32'(commitValid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd84, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("t1_cnt1", 32'(sbCount), 32'd1);
    checkCommit("t1_c", 32'd84, 32'd7);
    checkOutput("t1_fwd", readdata, 32'd7);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_cnt2", 32'(sbCount), 32'd0);
    checkOutput("t1_idle", 32'(commitValid), 32'd0);
    checkOutput("t1_ram", readdata, 32'd7);

    // Fill while busy, stall on the fifth store, then drain in order.
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'(i + 1), 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 32'd16, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("t2_full", 32'(sbCount), 32'd4);
    checkOutput("t2_stall", 32'(stall), 32'd1);
    checkOutput("t2_nocommit", 32'(commitValid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_hold_cnt", 32'(sbCount), 32'd4);
    checkOutput("t2_hold_stall", 32'(stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'd16, 32'd5, 1'b0);
    @(negedge clk);
    checkOutput("t2_stall_drain", 32'(stall), 32'd1);
    checkCommit("t2_c0", 32'd0, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_cnt3", 32'(sbCount), 32'd3);
    checkOutput("t2_unstall", 32'(stall), 32'd0);
    checkCommit("t2_c1", 32'd4, 32'd2);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_cnt3b", 32'(sbCount), 32'd3);
    checkCommit("t2_c2", 32'd8, 32'd3);
    nextCycle();
    @(negedge clk);
    checkCommit("t2_c3", 32'd12, 32'd4);
    nextCycle();
    @(negedge clk);
    checkCommit("t2_c4", 32'd16, 32'd5);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_empty", 32'(sbCount), 32'd0);
    checkOutput("t2_idle", 32'(commitValid), 32'd0);

    // Two stores to the same word: newest forwards, later one lands last.
    nextCycle();
    applyStimulus(1'b1, 32'd80, 32'hA, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 32'd80, 32'hB, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd80, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t3_cnt", 32'(sbCount), 32'd2);
    checkOutput("t3_fwd", readdata, 32'hB);
    nextCycle();
    applyStimulus(1'b0, 32'd80, 32'd0, 1'b0);
    @(negedge clk);
    checkCommit("t3_c0", 32'd80, 32'hA);
    checkOutput("t3_fwd2", readdata, 32'hB);
    nextCycle();
    @(negedge clk);
    checkCommit("t3_c1", 32'd80, 32'hB);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_empty", 32'(sbCount), 32'd0);
    checkOutput("t3_ram", readdata, 32'hB);

    // Continuous push and drain; pointers wrap past the buffer depth.
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(100 + 4 * i), 32'(256 + i), 1'b0);
      @(negedge clk);
      checkOutput("t4_stall", 32'(stall), 32'd0);
      if (i == 0) begin
        checkOutput("t4_first", 32'(commitValid), 32'd0);
      end else begin
        checkOutput("t4_cnt", 32'(sbCount), 32'd1);
        checkCommit("t4_c", 32'(100 + 4 * (i - 1)), 32'(256 + i - 1));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkCommit("t4_last", 32'd136, 32'h109);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_empty", 32'(sbCount), 32'd0);

    // Address wrap and ignored byte offset.
    nextCycle();
    applyStimulus(1'b1, 32'd260, 32'h55, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'd85, 32'h66, 1'b0);
    @(negedge clk);
    checkCommit("t5_wrap", 32'd4, 32'h55);
    nextCycle();
    applyStimulus(1'b0, 32'd4, 32'd0, 1'b0);
    @(negedge clk);
    checkCommit("t5_byte", 32'd84, 32'h66);
    checkOutput("t5_ram", readdata, 32'h55);
    nextCycle();

    // Async reset mid-operation discards buffered stores.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(200 + 4 * i), 32'(i + 9), 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 32'd212, 32'd12, 1'b1);
    @(negedge clk);
    checkOutput("t6_cnt3", 32'(sbCount), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_cnt", 32'(sbCount), 32'd0);
    checkOutput("t6_rst_stall", 32'(stall), 32'd0);
    checkOutput("t6_rst_cv", 32'(commitValid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_nocommit", 32'(commitValid), 32'd0);
      checkOutput("t6_cnt", 32'(sbCount), 32'd0);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory responder on the CPU's data port (`dataadr` / `writedata` / `memwrite` → `readdata`).
- Stores are queued in a small FIFO store buffer and drained one per cycle into an internal word RAM whenever the RAM port is free (`mem_busy` low).
- Loads see the newest buffered data through forwarding.
- Full buffer stalls the CPU.
- A commit strobe exposes every RAM write so benches can check stores at the memory end instead of at the CPU pins.

Parameters:
- MEM_WORDS, 64, RAM depth in 32-bit words (power of two).
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- memwrite  in  1  CPU store request this cycle.
- dataadr  in  32  CPU byte address. Word index = `dataadr[log2(MEM_WORDS)+1:2]`; bits [1:0] and upper bits ignored, so addresses wrap.
- writedata  in  32  store data.
- mem_busy  in  1  RAM port unavailable this cycle; blocks drain.
- readdata  out  32  load data, combinational.
- stall  out  1  store not accepted this cycle; CPU must hold `memwrite` / `dataadr` / `writedata`.
- sb_count  out  log2(SB_DEPTH)+1  occupied entries, registered.
- commit_valid  out  1  RAM written at this rising edge.
- commit_addr  out  32  word-aligned byte address of that write ({index, 2'b00}, zero-extended).
- commit_data  out  32  data of that write.

Behaviour:
- Reset (`rst` low, async):
  - head/tail/count cleared; `sb_count`=0, `stall`=0, `commit_valid`=0.
  - `commit_addr` and `commit_data` = 0.
  - RAM contents not reset.
  - All buffered stores are discarded when reset asserts mid-operation.
- Push:
  - `memwrite` & !`stall` → entry {index, writedata} written at tail on the rising edge; tail++ mod SB_DEPTH.
- Stall:
  - `stall` = `memwrite` & (`sb_count` == SB_DEPTH), combinational.
  - Asserted even if a drain occurs the same cycle (no same-cycle full-bypass).
  - `stall` is 0 whenever `memwrite` is 0.
- Drain:
  - (`sb_count` != 0) & !`mem_busy` → head entry written to RAM on the rising edge; head++.
  - `commit_valid`/`commit_addr`/`commit_data` are combinational this same cycle (describe the write taking effect at that edge).
- Simultaneous push and drain:
  - count unchanged; both pointers advance.
  - Push only: count+1. Drain only: count−1.
- Ordering:
  - Drain strictly FIFO; RAM write order equals CPU store order.
  - Multiple entries may hold the same index; the later one lands last.
- Load path:
  - `readdata` = data of the newest valid buffer entry whose index matches `dataadr`; otherwise RAM[index].
  - "Newest" is by age from tail backwards, not by slot number.
  - The entry being drained this cycle is still valid for forwarding, and RAM also holds it after the edge, so the result is consistent.
  - A same-cycle store does not forward to itself: `readdata` reflects state before the edge.
- `sb_count` never exceeds SB_DEPTH and never underflows.
- Pointer wrap handled by modulo arithmetic.

Test Plan:
- Reset, then `memwrite`=1 to `dataadr`=84, `writedata`=7, `mem_busy`=0 for 1 cycle → next cycle `commit_valid`=1, `commit_addr`=84, `commit_data`=7, `sb_count` returns to 0; reading addr 84 gives 7.
- `mem_busy`=1; stores to 0, 4, 8, 12 (data 1..4), then a 5th to 16 → `sb_count`=4 and `stall`=1 on the 5th while held. Release `mem_busy` → commits 0,4,8,12 in order on 4 consecutive cycles; `stall` drops after the first drain and the store to 16 is accepted.
- `mem_busy`=1; store 80←0xA then 80←0xB → `readdata` at 80 = 0xB while both are buffered. Release → two commits to 80, final RAM value 0xB.
- Push and drain every cycle for 10 cycles (`mem_busy`=0, continuous stores) → `sb_count` stays 1 after the first cycle, no stall, pointers wrap past SB_DEPTH, commit order matches store order.
- Store to 260 with MEM_WORDS=64 → `commit_addr`=4 (wrap). Byte address 85 → `commit_addr`=84.
- Fill 3 entries with `mem_busy`=1, then assert `rst` low mid-cycle → `sb_count`=0 and `stall`=0 immediately (async). No commits occur after reset release.
